// File: rtl/instrumented_adder_meter.sv
`default_nettype none
// ============================================================================
// Module : instrumented_adder_meter -- adder sum check + ring-osc edge counter
// Rev    : 1.0
// ============================================================================
module instrumented_adder_meter #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          active,
    input  logic                          start,
    input  logic [WIDTH-1:0]              cfg_a,
    input  logic [WIDTH-1:0]              cfg_b,
    input  logic [$clog2(CHANNELS)-1:0]   cfg_sel,
    input  logic [CNT_W-1:0]              cfg_period,
    input  logic [CHANNELS-1:0]           osc_in,
    input  logic [CHANNELS*WIDTH-1:0]     sum_in,
    output logic [WIDTH-1:0]              a_out,
    output logic [WIDTH-1:0]              b_out,
    output logic [CHANNELS-1:0]           osc_en,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              count,
    output logic                          overflow,
    output logic                          sum_err,
    output logic                          sel_err,
    output logic [WIDTH-1:0]              sum_out
);

    localparam int                SEL_W       = $clog2(CHANNELS);
    localparam logic [SEL_W:0]    C_NCH       = (SEL_W+1)'(CHANNELS);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  C_SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  C_DRAIN_LD  = CNT_W'(SYNC_STAGES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CHECK  = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     timer_q, timer_d;
    logic [WIDTH-1:0]                     a_q, b_q, sum_out_q;
    logic [SEL_W-1:0]                     sel_q;
    logic [CNT_W-1:0]                     period_q, count_q;
    logic                                 overflow_q, sum_err_q, sel_err_q;
    logic [CHANNELS-1:0]                  osc_en_q;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  last_q;

    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_en_sel;
    logic                w_rise_sel;
    logic [WIDTH-1:0]    w_sum_sel;
    logic [WIDTH-1:0]    w_sum_ref;
    logic                w_sel_bad;
    logic                w_accept;
    logic                w_abort;

    assign w_rise    = sync_q[SYNC_STAGES-1] & ~last_q;
    assign w_sum_ref = a_q + b_q;
    assign w_sel_bad = ({1'b0, sel_q} >= C_NCH);
    assign w_accept  = (state_q == S_IDLE) && start && active;
    // DONE is left alone so a completed result is never wiped by a late abort.
    assign w_abort   = !active && (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        w_rise_sel = 1'b0;
        w_sum_sel  = '0;
        w_en_sel   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_q == SEL_W'(c)) begin
                w_rise_sel  = w_rise[c];
                w_sum_sel   = sum_in[c*WIDTH +: WIDTH];
                w_en_sel[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            sync_q <= '0;
            last_q <= '0;
        end else begin
            sync_q[0] <= osc_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start && active) begin
                    state_d = S_SETTLE;
                    timer_d = C_SETTLE_LD;
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) state_d = S_CHECK;
                else               timer_d = timer_q - 1'b1;
            end
            S_CHECK: begin
                if (w_sel_bad) begin
                    state_d = S_DONE;
                end else if (period_q == '0) begin
                    state_d = S_DRAIN;
                    timer_d = C_DRAIN_LD;
                end else begin
                    state_d = S_RUN;
                    timer_d = period_q - 1'b1;
                end
            end
            S_RUN: begin
                if (timer_q == '0) begin
                    state_d = S_DRAIN;
                    timer_d = C_DRAIN_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (timer_q == '0) state_d = S_DONE;
                else               timer_d = timer_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (w_abort) state_d = S_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            period_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sum_err_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            sum_out_q  <= '0;
            osc_en_q   <= '0;
        end else begin
            osc_en_q <= (state_d == S_RUN) ? w_en_sel : '0;
            if (w_accept || w_abort) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
                sum_err_q  <= 1'b0;
                sel_err_q  <= 1'b0;
                sum_out_q  <= '0;
                if (w_accept) begin
                    a_q      <= cfg_a;
                    b_q      <= cfg_b;
                    sel_q    <= cfg_sel;
                    period_q <= cfg_period;
                end
            end else begin
                if (state_q == S_CHECK) begin
                    if (w_sel_bad) begin
                        sel_err_q <= 1'b1;
                    end else begin
                        sum_out_q <= w_sum_sel;
                        sum_err_q <= (w_sum_sel != w_sum_ref);
                    end
                end
                // Counter saturates; overflow marks that the ceiling was reached.
                if ((state_q == S_RUN || state_q == S_DRAIN) && w_rise_sel) begin
                    if (count_q != C_CNT_MAX)          count_q    <= count_q + 1'b1;
                    if (count_q >= C_CNT_MAX - 1'b1)   overflow_q <= 1'b1;
                end
            end
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign osc_en   = osc_en_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign sum_err  = sum_err_q;
    assign sel_err  = sel_err_q;
    assign sum_out  = sum_out_q;

endmodule
`default_nettype wire
